// File: rtl/tli4970_pkg.sv
// Shared definitions for the TLI4970 SPI responder: frame layout, FSM
// encoding and the frame builder used at snapshot time.
package tli4970_pkg;

    localparam int FRAME_LEN  = 16;
    localparam int PAYLOAD_W  = 13;
    localparam int BIT_TYPE   = 15;
    localparam int BIT_PARITY = 14;
    localparam int BIT_OCD    = 13;

    localparam int                CNT_W    = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Parity is computed with the parity slot still zero, so writing the
    // XOR back into it makes the XOR over all 16 bits equal zero.
    function automatic logic [FRAME_LEN-1:0] build_frame(
        input logic                 is_status,
        input logic                 ocd,
        input logic [PAYLOAD_W-1:0] payload
    );
        logic [FRAME_LEN-1:0] f;
        f                  = '0;
        f[BIT_TYPE]        = is_status;
        f[BIT_OCD]         = ocd & ~is_status;
        f[PAYLOAD_W-1:0]   = payload;
        f[BIT_PARITY]      = ^f;
        return f;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous input with single-cycle
// rise/fall strobes derived from the synchronised copy.
module sync_edge #(
    parameter int   STAGES     = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic CLK,
    input  logic reset,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic [STAGES:0]   armed_q, armed_d;

    // Edges stay masked until the chain has flushed its reset value, so a
    // line already at its active level when reset releases is not an edge.
    always_comb begin
        sync_d  = {sync_q[STAGES-2:0], async_i};
        prev_d  = sync_q[STAGES-1];
        armed_d = {armed_q[STAGES-1:0], 1'b1};
    end

    // NOTE: flops use non-blocking assignment so every one samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (reset) begin
            sync_q  <= {STAGES{IDLE_LEVEL}};
            prev_q  <= IDLE_LEVEL;
            armed_q <= '0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
        end
    end

    assign rise_o = armed_q[STAGES] &  sync_q[STAGES-1] & ~prev_q;
    assign fall_o = armed_q[STAGES] & ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/tli4970_responder.sv
// SPI mode-0 slave emulating the TLI4970 current sensor readout: snapshots a
// current or status frame at CS fall and shifts it out MSB first.
module tli4970_responder
    import tli4970_pkg::*;
#(
    parameter int CURRENT_W   = 13,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 spi_sck_i,
    input  logic                 spi_ssel_i,
    output logic                 spi_miso_o,
    output logic                 miso_oe,
    input  logic [CURRENT_W-1:0] current_i,
    input  logic                 ocd_i,
    input  logic                 status_req,
    input  logic [PAYLOAD_W-1:0] status_i,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic [15:0]          frame_count
);

    logic sck_rise, sck_fall, cs_rise, cs_fall;

    sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sck_sync (
        .CLK(CLK), .reset(reset), .async_i(spi_sck_i),
        .rise_o(sck_rise), .fall_o(sck_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_cs_sync (
        .CLK(CLK), .reset(reset), .async_i(spi_ssel_i),
        .rise_o(cs_rise), .fall_o(cs_fall)
    );

    logic [PAYLOAD_W-1:0] cur_payload;
    logic [FRAME_LEN-1:0] snapshot;

    if (CURRENT_W >= PAYLOAD_W) begin : g_trunc
        assign cur_payload = current_i[PAYLOAD_W-1:0];
    end else begin : g_sext
        assign cur_payload = {{(PAYLOAD_W-CURRENT_W){current_i[CURRENT_W-1]}}, current_i};
    end

    assign snapshot = build_frame(status_req, ocd_i, status_req ? status_i : cur_payload);

    state_e               state_q, state_d;
    logic [FRAME_LEN-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 miso_q, miso_d;
    logic                 oe_q, oe_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [15:0]          frame_count_q, frame_count_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d       = state_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        miso_d        = miso_q;
        oe_d          = oe_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        frame_count_d = frame_count_q;

        unique case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                oe_d   = 1'b0;
                if (cs_fall) begin
                    shreg_d   = snapshot;
                    bit_cnt_d = '0;
                    miso_d    = snapshot[FRAME_LEN-1];
                    oe_d      = 1'b1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A CS rise in the same sample as the last SCK rise still completes the frame.
                if (sck_rise && bit_cnt_q == LAST_BIT) begin
                    done_d        = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = cs_rise ? ST_IDLE : ST_DRAIN;
                    if (cs_rise) begin
                        oe_d   = 1'b0;
                        miso_d = 1'b0;
                    end
                end else if (cs_rise) begin
                    err_d   = 1'b1;
                    oe_d    = 1'b0;
                    miso_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (sck_rise) begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end else if (sck_fall && bit_cnt_q != '0) begin
                    shreg_d = {shreg_q[FRAME_LEN-2:0], 1'b0};
                    miso_d  = shreg_q[FRAME_LEN-2];
                end
            end
            ST_DRAIN: begin
                if (cs_rise) begin
                    oe_d    = 1'b0;
                    miso_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (sck_rise || sck_fall) begin
                    miso_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            miso_q        <= 1'b0;
            oe_q          <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            miso_q        <= miso_d;
            oe_q          <= oe_d;
            done_q        <= done_d;
            err_q         <= err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign spi_miso_o  = miso_q;
    assign miso_oe     = oe_q;
    assign frame_done  = done_q;
    assign frame_err   = err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_tli4970_responder.sv
// Scoreboard bench for tli4970_responder: a bench-side SPI master clocks
// frames at CLK/32 and a monitor checks each frame end against the queue.
`timescale 1ns/1ps
module tb_tli4970_responder;

    localparam int HALF        = 16;
    localparam int SYNC_STAGES = 2;

    logic        CLK = 1'b0;
    logic        reset;
    logic        spi_sck_i, spi_ssel_i;
    logic        spi_miso_o, miso_oe;
    logic [12:0] current_i;
    logic        ocd_i, status_req;
    logic [12:0] status_i;
    logic        frame_done, frame_err;
    logic [15:0] frame_count;

    tli4970_responder #(.CURRENT_W(13), .SYNC_STAGES(SYNC_STAGES)) dut (
        .CLK(CLK), .reset(reset),
        .spi_sck_i(spi_sck_i), .spi_ssel_i(spi_ssel_i),
        .spi_miso_o(spi_miso_o), .miso_oe(miso_oe),
        .current_i(current_i), .ocd_i(ocd_i),
        .status_req(status_req), .status_i(status_i),
        .frame_done(frame_done), .frame_err(frame_err),
        .frame_count(frame_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        exp_done;
        logic        exp_err;
        logic        chk_word;
        logic [15:0] word;
        logic        chk_extra;
        logic [15:0] count;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] rx_word;
    logic [3:0]  rx_extra;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_frame(input logic done, input logic err, input logic chk_word,
                                input logic [15:0] word, input logic chk_extra,
                                input logic [15:0] count);
        exp_t e;
        e.exp_done  = done;
        e.exp_err   = err;
        e.chk_word  = chk_word;
        e.word      = word;
        e.chk_extra = chk_extra;
        e.count     = count;
        exp_q.push_back(e);
    endtask

    // Monitor: a frame ends when miso_oe drops; pulses seen since the last end are judged then.
    initial begin : monitor
        int   done_seen = 0;
        int   err_seen  = 0;
        bit   oe_seen   = 1'b0;
        exp_t e;
        forever begin
            @(negedge CLK);
            if (frame_done === 1'b1) done_seen++;
            if (frame_err === 1'b1) err_seen++;
            if (oe_seen && miso_oe === 1'b0) begin
                check("frame_end_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("frame_done_pulses", 32'(done_seen), 32'(e.exp_done));
                    check("frame_err_pulses", 32'(err_seen), 32'(e.exp_err));
                    check("frame_count", 32'(frame_count), 32'(e.count));
                    if (e.chk_word) check("rx_word", 32'(rx_word), 32'(e.word));
                    if (e.chk_extra) check("rx_drain_bits", 32'(rx_extra), 32'd0);
                end
                done_seen = 0;
                err_seen  = 0;
            end
            oe_seen = (miso_oe === 1'b1);
        end
    end

    task automatic spi_xfer(input int n_sck, input int poke_at, input int reset_at, input bit meas_oe);
        int n;
        rx_word  = '0;
        rx_extra = '0;
        @(negedge CLK);
        spi_ssel_i = 1'b0;
        repeat (HALF) @(negedge CLK);
        for (int i = 0; i < n_sck; i++) begin
            if (i == poke_at) begin
                current_i  = 13'h1555;
                ocd_i      = 1'b1;
                status_req = 1'b1;
                status_i   = 13'h1FFF;
            end
            if (i == reset_at) begin
                reset = 1'b1;
                repeat (3) @(negedge CLK);
                reset = 1'b0;
            end
            if (i < 16) rx_word[15-i] = spi_miso_o;
            else if (i < 20) rx_extra[19-i] = spi_miso_o;
            spi_sck_i = 1'b1;
            repeat (HALF) @(negedge CLK);
            spi_sck_i = 1'b0;
            repeat (HALF) @(negedge CLK);
        end
        spi_ssel_i = 1'b1;
        if (meas_oe) begin
            n = 0;
            do begin
                @(posedge CLK);
                #1;
                n++;
            end while (miso_oe !== 1'b0 && n < 20);
            check("oe_low_after_cs_release", 32'(miso_oe), 32'd0);
            check("oe_release_within_bound", 32'(n <= SYNC_STAGES + 1), 32'd1);
        end
        repeat (24) @(negedge CLK);
    endtask

    task automatic set_inputs(input logic [12:0] cur, input logic ocd, input logic sreq, input logic [12:0] stat);
        current_i  = cur;
        ocd_i      = ocd;
        status_req = sreq;
        status_i   = stat;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset      = 1'b1;
        spi_sck_i  = 1'b0;
        spi_ssel_i = 1'b1;
        set_inputs(13'h0000, 1'b0, 1'b0, 13'h0000);
        repeat (4) @(posedge CLK);
        #1;
        check("reset_miso", 32'(spi_miso_o), 32'd0);
        check("reset_oe", 32'(miso_oe), 32'd0);
        check("reset_done", 32'(frame_done), 32'd0);
        check("reset_err", 32'(frame_err), 32'd0);
        check("reset_count", 32'(frame_count), 32'd0);
        @(negedge CLK);
        reset = 1'b0;
        repeat (8) @(negedge CLK);

        // SCK activity with CS high must be ignored.
        for (int i = 0; i < 4; i++) begin
            spi_sck_i = 1'b1;
            repeat (HALF) @(negedge CLK);
            spi_sck_i = 1'b0;
            repeat (HALF) @(negedge CLK);
        end
        check("idle_sck_oe", 32'(miso_oe), 32'd0);
        check("idle_sck_count", 32'(frame_count), 32'd0);

        // Positive current, even parity already satisfied.
        set_inputs(13'h0123, 1'b0, 1'b0, 13'h0000);
        expect_frame(1'b1, 1'b0, 1'b1, 16'h0123, 1'b0, 16'd1);
        spi_xfer(16, -1, -1, 1'b0);

        // -5 with over-current: 13 ones in bits 13:0 force the parity bit.
        set_inputs(13'h1FFB, 1'b1, 1'b0, 13'h0000);
        expect_frame(1'b1, 1'b0, 1'b1, 16'h7FFB, 1'b0, 16'd2);
        spi_xfer(16, -1, -1, 1'b0);

        // Status frame: ocd_i is ignored, bit 13 stays clear.
        set_inputs(13'h0ABC, 1'b1, 1'b1, 13'h0004);
        expect_frame(1'b1, 1'b0, 1'b1, 16'h8004, 1'b0, 16'd3);
        spi_xfer(16, -1, -1, 1'b0);

        // CS released after 7 SCK.
        set_inputs(13'h0123, 1'b0, 1'b0, 13'h0000);
        expect_frame(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd3);
        spi_xfer(7, -1, -1, 1'b1);

        // 20 SCK, inputs disturbed mid-frame.
        set_inputs(13'h0AAA, 1'b0, 1'b0, 13'h0000);
        expect_frame(1'b1, 1'b0, 1'b1, 16'h0AAA, 1'b1, 16'd4);
        spi_xfer(20, 3, -1, 1'b0);

        // Counter wrap from 0xFFFF.
        @(negedge CLK);
        dut.frame_count_q = 16'hFFFF;
        set_inputs(13'h1000, 1'b0, 1'b0, 13'h0000);
        expect_frame(1'b1, 1'b0, 1'b1, 16'h5000, 1'b0, 16'd0);
        spi_xfer(16, -1, -1, 1'b0);

        // Reset at bit 9 aborts silently; next frame starts clean.
        set_inputs(13'h0001, 1'b0, 1'b0, 13'h0000);
        expect_frame(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'd0);
        spi_xfer(16, -1, 9, 1'b0);
        check("post_reset_oe", 32'(miso_oe), 32'd0);
        set_inputs(13'h0F0F, 1'b1, 1'b0, 13'h0000);
        expect_frame(1'b1, 1'b0, 1'b1, 16'h6F0F, 1'b0, 16'd1);
        spi_xfer(16, -1, -1, 1'b0);

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge CLK);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
